instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/ifetch_pkg.sv | 18 +
 rtl/ifetch_fifo.sv | 54 +++++
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and widths for the instruction fetch unit and its buffer.
package ifetch_pkg;

    localparam int INSTR_W = 32;
    localparam int IMEM_AW = 8;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } ifetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush empties it in one cycle.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output fetch_entry_t  head_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Storage is cleared on reset so the head reads as zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: credit-limited requests to a 1-cycle imem, buffered for decode.
// Optional pop/redirect statistics counters are built when IFETCH_STATS_EN is defined.
module instr_fetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_rd_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_pc_plus_1,
    output ifetch_state_e      dbg_state
`ifdef IFETCH_STATS_EN
    ,
    output logic [15:0]        stat_fetched,
    output logic [15:0]        stat_flushes
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ifetch_state_e state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   req_pc_q;
    logic          inflight_q;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   credit_use;

    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;
    // Entries held plus the response on its way, less the one leaving now.
    assign credit_use = (CW+1)'(fifo_count) + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign issue      = !rst && (state_q != BOOT) && (credit_use < (CW+1)'(FIFO_DEPTH));
    assign push       = inflight_q && !redirect_valid;

    assign imem_rd_en = issue;
    assign imem_addr  = rst ? RESET_PC[IMEM_AW-1:0] : fetch_pc_q[IMEM_AW-1:0];
    assign push_entry = '{pc: req_pc_q, instr: imem_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue && !redirect_valid;
            if (issue) begin
                req_pc_q <= fetch_pc_q;
            end
            if (redirect_valid) begin
                fetch_pc_q <= redirect_pc;
            end else if (issue) begin
                fetch_pc_q <= fetch_pc_q + 32'd1;
            end
            case (state_q)
                BOOT:       state_q <= RUN;
                RUN, FLUSH: state_q <= redirect_valid ? FLUSH : RUN;
                default:    state_q <= BOOT;
            endcase
        end
    end

    ifetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .head_o      (head)
    );

    assign out_instr     = head.instr;
    assign out_pc        = head.pc;
    assign out_pc_plus_1 = head.pc + 32'd1;
    assign dbg_state     = state_q;

`ifdef IFETCH_STATS_EN
    logic [15:0] stat_fetched_q;
    logic [15:0] stat_flushes_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetched_q <= '0;
            stat_flushes_q <= '0;
        end else begin
            if (pop && (stat_fetched_q != 16'hFFFF)) begin
                stat_fetched_q <= stat_fetched_q + 16'd1;
            end
            if (redirect_valid && (stat_flushes_q != 16'hFFFF)) begin
                stat_flushes_q <= stat_flushes_q + 16'd1;
            end
        end
    end

    assign stat_fetched = stat_fetched_q;
    assign stat_flushes = stat_flushes_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + random bench for instr_fetch_unit with a stream-level reference model.
// Valid/ready: a decode transfer happens on a posedge where out_valid and out_ready are both 1.
module tb_instr_fetch_unit;
  import ifetch_pkg::*;

  localparam int DEPTH = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          out_ready;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          imem_rd_en;
  logic [7:0]    imem_addr;
  logic [31:0]   imem_data;
  logic          out_valid;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic [31:0]   out_pc_plus_1;
  ifetch_state_e dbg_state;
`ifdef IFETCH_STATS_EN
  logic [15:0]   stat_fetched;
  logic [15:0]   stat_flushes;
  logic [15:0]   stat_fetched_w;
  logic [15:0]   stat_flushes_w;
`endif

  logic          rst_w;
  logic          imem_rd_en_w;
  logic [7:0]    imem_addr_w;
  logic [31:0]   imem_data_w;
  logic          out_valid_w;
  logic [31:0]   out_instr_w;
  logic [31:0]   out_pc_w;
  logic [31:0]   out_pc_plus_1_w;
  ifetch_state_e dbg_state_w;

  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(.RESET_PC(32'd0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_plus_1(out_pc_plus_1), .dbg_state(dbg_state)
`ifdef IFETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_flushes(stat_flushes)
`endif
  );

  instr_fetch_unit #(.RESET_PC(32'd254), .FIFO_DEPTH(DEPTH)) dut_w (
    .clk(clk), .rst(rst_w), .imem_rd_en(imem_rd_en_w), .imem_addr(imem_addr_w),
    .imem_data(imem_data_w), .redirect_valid(1'b0), .redirect_pc(32'd0),
    .out_valid(out_valid_w), .out_ready(1'b1), .out_instr(out_instr_w), .out_pc(out_pc_w),
    .out_pc_plus_1(out_pc_plus_1_w), .dbg_state(dbg_state_w)
`ifdef IFETCH_STATS_EN
    , .stat_fetched(stat_fetched_w), .stat_flushes(stat_flushes_w)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return 32'hA0 + {24'd0, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one call is one clock cycle; inputs change just after the edge, checks at negedge
  task automatic go(input logic r, input logic rdy, input logic rv, input logic [31:0] rp);
    @(posedge clk);
    #1;
    rst = r;
    out_ready = rdy;
    redirect_valid = rv;
    redirect_pc = rp;
    @(negedge clk);
  endtask

  // instruction memory: data for a request appears during the following cycle
  logic       pend_v = 1'b0;
  logic       pend_v_w = 1'b0;
  logic [7:0] pend_a = 8'd0;
  logic [7:0] pend_a_w = 8'd0;
  always @(negedge clk) begin
    pend_v = imem_rd_en;
    pend_a = imem_addr;
    pend_v_w = imem_rd_en_w;
    pend_a_w = imem_addr_w;
  end
  always @(posedge clk) begin
    #1;
    imem_data = pend_v ? mem_word(pend_a) : 32'hDEADBEEF;
    imem_data_w = pend_v_w ? mem_word(pend_a_w) : 32'hDEADBEEF;
  end

  // scoreboard: the delivered stream is consecutive PCs, restarting at reset or redirect target
  logic [31:0] exp_pc = 32'd0;
  logic [31:0] exp_fetch = 32'd0;
  int          outst = 0;
  int          pops_since_rst = 0;
  always @(negedge clk) begin
    if (rst) begin
      exp_pc = 32'd0;
      exp_fetch = 32'd0;
      outst = 0;
      pops_since_rst = 0;
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_pc", out_pc, exp_pc);
        chk("sb_instr", out_instr, mem_word(exp_pc[7:0]));
        chk("sb_pc_plus_1", out_pc_plus_1, exp_pc + 32'd1);
        exp_pc++;
        pops_since_rst++;
        outst--;
      end
      if (imem_rd_en) begin
        chk("fetch_addr", 32'(imem_addr), 32'(exp_fetch[7:0]));
        exp_fetch++;
        outst++;
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc;
        exp_fetch = redirect_pc;
        outst = 0;
      end else begin
        chk("credit_bound", 32'(outst <= DEPTH), 32'd1);
      end
    end
  end

  // wrap instance: first four requests and deliveries from RESET_PC=254
  int nreq_w = 0;
  int npop_w = 0;
  always @(negedge clk) begin
    if (!rst_w) begin
      if (imem_rd_en_w && nreq_w < 4) begin
        chk("wrap_addr", 32'(imem_addr_w), 32'((254 + nreq_w) % 256));
        nreq_w++;
      end
      if (out_valid_w && npop_w < 4) begin
        chk("wrap_pc", out_pc_w, 32'd254 + 32'(npop_w));
        chk("wrap_pc_plus_1", out_pc_plus_1_w, 32'd255 + 32'(npop_w));
        chk("wrap_instr", out_instr_w, mem_word(8'((254 + npop_w) % 256)));
        npop_w++;
      end
    end
  end

  logic        r_r;
  logic        r_rdy;
  logic        r_rv;
  logic [31:0] r_rp;

  initial begin
    rst = 1'b1;
    rst_w = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    imem_data = 32'd0;
    imem_data_w = 32'd0;

    // reset values
    go(1, 1, 0, 0); go(1, 1, 0, 0); go(1, 1, 0, 0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rd_en", 32'(imem_rd_en), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(BOOT));
    rst_w = 1'b0;

    // first delivery three cycles after release, then one per cycle
    go(0, 1, 0, 0);
    chk("boot_valid", 32'(out_valid), 32'd0);
    chk("boot_rd_en", 32'(imem_rd_en), 32'd0);
    chk("boot_state", 32'(dbg_state), 32'(BOOT));
    go(0, 1, 0, 0);
    chk("req_rd_en", 32'(imem_rd_en), 32'd1);
    chk("req_addr", 32'(imem_addr), 32'd0);
    chk("req_valid", 32'(out_valid), 32'd0);
    go(0, 1, 0, 0);
    chk("push_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      go(0, 1, 0, 0);
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("stream_pc", out_pc, 32'(i));
      chk("stream_instr", out_instr, 32'hA0 + 32'(i));
    end

    // backpressure: two requests outstanding, head held
    go(1, 0, 0, 0);
    go(0, 0, 0, 0);
    go(0, 0, 0, 0);
    go(0, 0, 0, 0);
    chk("stall_second_req", 32'(imem_rd_en), 32'd1);
    for (int i = 0; i < 5; i++) begin
      go(0, 0, 0, 0);
      chk("stall_rd_en", 32'(imem_rd_en), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_head", out_pc, 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      go(0, 1, 0, 0);
      chk("release_valid", 32'(out_valid), 32'd1);
      chk("release_pc", out_pc, 32'(i));
    end

    // redirect while the buffer holds pc 3 and 4
    go(0, 0, 0, 0);
    go(0, 0, 1, 32'd8);
    chk("redir_head", out_pc, 32'd3);
    go(0, 1, 0, 0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_addr", 32'(imem_addr), 32'd8);
    chk("flush_rd_en", 32'(imem_rd_en), 32'd1);
    chk("flush_state", 32'(dbg_state), 32'(FLUSH));
    go(0, 1, 0, 0);
    chk("post_flush_valid", 32'(out_valid), 32'd0);
    go(0, 1, 0, 0);
    chk("redir_target_valid", 32'(out_valid), 32'd1);
    chk("redir_target_pc", out_pc, 32'd8);

    // one-cycle reset mid-stream with a request in flight
    go(0, 1, 0, 0); go(0, 1, 0, 0); go(0, 1, 0, 0);
    go(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      go(0, 1, 0, 0);
      chk("midrst_valid_low", 32'(out_valid), 32'd0);
    end
    go(0, 1, 0, 0);
    chk("midrst_valid", 32'(out_valid), 32'd1);
    chk("midrst_pc", out_pc, 32'd0);

    // random traffic, checked by the scoreboard
    for (int i = 0; i < 3000; i++) begin
      r_r = ($urandom_range(0, 299) == 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      r_rv = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 2))
        0: r_rp = $urandom;
        1: r_rp = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        default: r_rp = 32'($urandom_range(240, 255));
      endcase
      go(r_r, r_rdy, r_rv, r_rp);
    end

`ifdef IFETCH_STATS_EN
    go(1, 0, 0, 0);
    go(0, 0, 0, 0); go(0, 0, 0, 0); go(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) go(0, 1, 0, 0);
    go(0, 0, 1, 32'd5); go(0, 0, 0, 0); go(0, 0, 1, 32'd6); go(0, 0, 0, 0);
    chk("stat_pops_seen", 32'(pops_since_rst), 32'd10);
    chk("stat_fetched", 32'(stat_fetched), 32'd10);
    chk("stat_flushes", 32'(stat_flushes), 32'd2);
    force dut.stat_fetched_q = 16'hFFFE;
    force dut.stat_flushes_q = 16'hFFFE;
    go(0, 0, 0, 0);
    release dut.stat_fetched_q;
    release dut.stat_flushes_q;
    go(0, 1, 1, 32'd7); go(0, 1, 1, 32'd7); go(0, 1, 1, 32'd7);
    for (int i = 0; i < 6; i++) go(0, 1, 0, 0);
    chk("stat_fetched_sat", 32'(stat_fetched), 32'hFFFF);
    chk("stat_flushes_sat", 32'(stat_flushes), 32'hFFFF);
`endif

    chk("wrap_reqs_seen", 32'(nreq_w), 32'd4);
    chk("wrap_pops_seen", 32'(npop_w), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
